// File: rtl/network_bf_in_if.sv
// ---------------------------------------------------------------------------
// network_bf_in_if
// Bundles the bank read data, the per-output bank selects and the routed
// butterfly operands of the read-side crossbar.
//   master : memory/controller side. Drives q0..q3, sel_b_0..3 and rd_en.
//            Receives bf_*, bf_valid, sel_conflict and conflict_err.
//   slave  : crossbar side (network_bf_in).
// ---------------------------------------------------------------------------
interface network_bf_in_if #(
    parameter int data_width = 14
);
    logic [data_width-1:0] q0;
    logic [data_width-1:0] q1;
    logic [data_width-1:0] q2;
    logic [data_width-1:0] q3;
    logic [1:0]            sel_b_0;
    logic [1:0]            sel_b_1;
    logic [1:0]            sel_b_2;
    logic [1:0]            sel_b_3;
    logic                  rd_en;
    logic [data_width-1:0] bf_0_upper;
    logic [data_width-1:0] bf_0_lower;
    logic [data_width-1:0] bf_1_upper;
    logic [data_width-1:0] bf_1_lower;
    logic                  bf_valid;
    logic                  sel_conflict;
    logic                  conflict_err;

    modport master (
        output q0, q1, q2, q3,
        output sel_b_0, sel_b_1, sel_b_2, sel_b_3, rd_en,
        input  bf_0_upper, bf_0_lower, bf_1_upper, bf_1_lower,
        input  bf_valid, sel_conflict, conflict_err
    );

    modport slave (
        input  q0, q1, q2, q3,
        input  sel_b_0, sel_b_1, sel_b_2, sel_b_3, rd_en,
        output bf_0_upper, bf_0_lower, bf_1_upper, bf_1_lower,
        output bf_valid, sel_conflict, conflict_err
    );
endinterface

// File: rtl/network_bf_in.sv
// ---------------------------------------------------------------------------
// network_bf_in
// Read-side crossbar of the radix-2, 2-BFU NTT datapath. Steers the four
// coefficient bank outputs onto the upper/lower inputs of BFU0 and BFU1.
// The bank selects arrive with the read address. They are delayed MEM_LAT
// cycles so they line up with the bank q data. The routed operands are then
// registered. Select sets are checked for duplicates at issue time.
//
// Ports:
//   clk  : system clock, rising edge.
//   rst  : synchronous, active-high reset.
//   bus  : network_bf_in_if.slave, which carries the following.
//          Inputs:  q0..q3 (bank read data), sel_b_0..3 (bank index for
//                   bf_0_upper, bf_0_lower, bf_1_upper, bf_1_lower) and
//                   rd_en (read issued, qualifies the selects).
//          Outputs: bf_* (registered operands), bf_valid (fresh operand
//                   set), sel_conflict (one-cycle duplicate-select pulse)
//                   and conflict_err (sticky conflict flag, cleared by rst).
//
// Parameters:
//   data_width : coefficient width in bits.
//   MEM_LAT    : bank read latency in cycles, 1..8.
// ---------------------------------------------------------------------------
module network_bf_in #(
    parameter int data_width = 14,
    parameter int MEM_LAT    = 1
) (
    input  logic          clk,
    input  logic          rst,
    network_bf_in_if.slave bus
);

    // Packed select set: [1:0]=bf_0_upper, [3:2]=bf_0_lower,
    // [5:4]=bf_1_upper, [7:6]=bf_1_lower.
    logic [7:0]            sel_p0;
    logic                  vld_p0;
    logic                  dup_p0;

    logic [7:0]            sel_dly [MEM_LAT];
    logic                  vld_dly [MEM_LAT];

    logic [7:0]            sel_p1;
    logic                  vld_p1;
    logic [data_width-1:0] mux_0u_p1;
    logic [data_width-1:0] mux_0l_p1;
    logic [data_width-1:0] mux_1u_p1;
    logic [data_width-1:0] mux_1l_p1;

    logic [data_width-1:0] bf_0u_p2;
    logic [data_width-1:0] bf_0l_p2;
    logic [data_width-1:0] bf_1u_p2;
    logic [data_width-1:0] bf_1l_p2;
    logic                  vld_p2;
    logic                  conflict_p2;
    logic                  conflict_err_p2;

    function automatic logic [data_width-1:0] bank_mux(
        input logic [1:0]            s,
        input logic [data_width-1:0] d0,
        input logic [data_width-1:0] d1,
        input logic [data_width-1:0] d2,
        input logic [data_width-1:0] d3
    );
        case (s)
            2'd0:    return d0;
            2'd1:    return d1;
            2'd2:    return d2;
            default: return d3;
        endcase
    endfunction

    // A legal set is a permutation of the four banks, so any equal pair is a conflict.
    function automatic logic has_dup(input logic [7:0] s);
        return (s[1:0] == s[3:2]) || (s[1:0] == s[5:4]) || (s[1:0] == s[7:6]) ||
               (s[3:2] == s[5:4]) || (s[3:2] == s[7:6]) || (s[5:4] == s[7:6]);
    endfunction

    // ---- stage p0: issue (selects arrive with the read address) ----
    assign sel_p0 = {bus.sel_b_3, bus.sel_b_2, bus.sel_b_1, bus.sel_b_0};
    assign vld_p0 = bus.rd_en;
    assign dup_p0 = has_dup(sel_p0);

    // Select delay line. It shifts every cycle, even when rd_en is low, so
    // the selects stay aligned with the memory pipeline. Reset flushes the
    // line so that no read issued before or during rst produces bf_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_LAT; i++) begin
                sel_dly[i] <= '0;
                vld_dly[i] <= 1'b0;
            end
        end else begin
            sel_dly[0] <= sel_p0;
            vld_dly[0] <= vld_p0;
            for (int i = 1; i < MEM_LAT; i++) begin
                sel_dly[i] <= sel_dly[i-1];
                vld_dly[i] <= vld_dly[i-1];
            end
        end
    end

    // ---- stage p1: delayed selects aligned with bank q data ----
    assign sel_p1 = sel_dly[MEM_LAT-1];
    assign vld_p1 = vld_dly[MEM_LAT-1];

    always_comb begin
        mux_0u_p1 = bank_mux(sel_p1[1:0], bus.q0, bus.q1, bus.q2, bus.q3);
        mux_0l_p1 = bank_mux(sel_p1[3:2], bus.q0, bus.q1, bus.q2, bus.q3);
        mux_1u_p1 = bank_mux(sel_p1[5:4], bus.q0, bus.q1, bus.q2, bus.q3);
        mux_1l_p1 = bank_mux(sel_p1[7:6], bus.q0, bus.q1, bus.q2, bus.q3);
    end

    // ---- stage p2: registered operands and status ----
    // Operands update only on a valid slot and hold otherwise. The conflict
    // flags come from the issue-time selects, so they lead the data by MEM_LAT.
    always_ff @(posedge clk) begin
        if (rst) begin
            bf_0u_p2        <= '0;
            bf_0l_p2        <= '0;
            bf_1u_p2        <= '0;
            bf_1l_p2        <= '0;
            vld_p2          <= 1'b0;
            conflict_p2     <= 1'b0;
            conflict_err_p2 <= 1'b0;
        end else begin
            vld_p2          <= vld_p1;
            conflict_p2     <= vld_p0 & dup_p0;
            conflict_err_p2 <= conflict_err_p2 | (vld_p0 & dup_p0);
            if (vld_p1) begin
                bf_0u_p2 <= mux_0u_p1;
                bf_0l_p2 <= mux_0l_p1;
                bf_1u_p2 <= mux_1u_p1;
                bf_1l_p2 <= mux_1l_p1;
            end
        end
    end

    assign bus.bf_0_upper   = bf_0u_p2;
    assign bus.bf_0_lower   = bf_0l_p2;
    assign bus.bf_1_upper   = bf_1u_p2;
    assign bus.bf_1_lower   = bf_1l_p2;
    assign bus.bf_valid     = vld_p2;
    assign bus.sel_conflict = conflict_p2;
    assign bus.conflict_err = conflict_err_p2;

endmodule

// File: tb/tb_network_bf_in.sv
// ---------------------------------------------------------------------------
// tb_network_bf_in
// Directed bench for network_bf_in. Three instances (MEM_LAT = 1, 3, 4) share
// one stimulus. Each scenario checks the instance whose latency it targets.
// Index 0 is MEM_LAT=1, index 1 is MEM_LAT=3 and index 2 is MEM_LAT=4.
// ---------------------------------------------------------------------------
module tb_network_bf_in;
    localparam int DW = 14;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] q   [4];
    logic [1:0]    sel [4];
    logic          rd_en;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] bu0 [3];
    logic [DW-1:0] bl0 [3];
    logic [DW-1:0] bu1 [3];
    logic [DW-1:0] bl1 [3];
    logic          vld  [3];
    logic          scf  [3];
    logic          cerr [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        network_bf_in_if #(.data_width(DW)) bus ();

        assign bus.q0      = q[0];
        assign bus.q1      = q[1];
        assign bus.q2      = q[2];
        assign bus.q3      = q[3];
        assign bus.sel_b_0 = sel[0];
        assign bus.sel_b_1 = sel[1];
        assign bus.sel_b_2 = sel[2];
        assign bus.sel_b_3 = sel[3];
        assign bus.rd_en   = rd_en;

        assign bu0[g]  = bus.bf_0_upper;
        assign bl0[g]  = bus.bf_0_lower;
        assign bu1[g]  = bus.bf_1_upper;
        assign bl1[g]  = bus.bf_1_lower;
        assign vld[g]  = bus.bf_valid;
        assign scf[g]  = bus.sel_conflict;
        assign cerr[g] = bus.conflict_err;

        network_bf_in #(
            .data_width(DW),
            .MEM_LAT   ((g == 0) ? 1 : ((g == 1) ? 3 : 4))
        ) dut (
            .clk(clk),
            .rst(rst),
            .bus(bus)
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_data(input int d, input string tag, input int a, input int b,
                            input int c, input int e);
        check({tag, "_0u"}, 32'(bu0[d]), a);
        check({tag, "_0l"}, 32'(bl0[d]), b);
        check({tag, "_1u"}, 32'(bu1[d]), c);
        check({tag, "_1l"}, 32'(bl1[d]), e);
    endtask

    // Inputs change 1 time unit after a rising edge and outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sel(input int s0, input int s1, input int s2, input int s3, input int en);
        sel[0] = 2'(s0);
        sel[1] = 2'(s1);
        sel[2] = 2'(s2);
        sel[3] = 2'(s3);
        rd_en  = en[0];
    endtask

    task automatic set_q(input int a, input int b, input int c, input int e);
        q[0] = DW'(a);
        q[1] = DW'(b);
        q[2] = DW'(c);
        q[3] = DW'(e);
    endtask

    task automatic idle(input int n);
        set_sel(0, 0, 0, 0, 0);
        repeat (n) tick();
    endtask

    initial begin
        // Reset with reads issued (duplicate selects) and random data.
        rst = 1'b1;
        set_sel(0, 0, 1, 1, 1);
        for (int c = 0; c < 3; c++) begin
            set_q($urandom, $urandom, $urandom, $urandom);
            tick();
            for (int d = 0; d < 3; d++) begin
                check("rst_vld",  32'(vld[d]),  0);
                check("rst_data", 32'(bu0[d]),  0);
                check("rst_scf",  32'(scf[d]),  0);
                check("rst_err",  32'(cerr[d]), 0);
            end
        end

        // First read after release. Each latency shows bf_valid at r+MEM_LAT+1.
        rst = 1'b0;
        set_q(101, 102, 103, 104);
        set_sel(0, 1, 2, 3, 1);
        tick();
        set_sel(0, 1, 2, 3, 0);
        for (int d = 0; d < 3; d++) check("rel_vld_r1", 32'(vld[d]), 0);
        check("rel_data_r1", 32'(bu0[0]), 0);
        check("rel_err_r1",  32'(cerr[0]), 0);
        tick();
        check("rel_vld_l1", 32'(vld[0]), 1);
        chk_data(0, "rel_l1", 101, 102, 103, 104);
        check("rel_vld_l3_early", 32'(vld[1]), 0);
        check("rel_vld_l4_early", 32'(vld[2]), 0);
        tick();
        for (int d = 0; d < 3; d++) check("rel_vld_r3", 32'(vld[d]), 0);
        tick();
        check("rel_vld_l3", 32'(vld[1]), 1);
        chk_data(1, "rel_l3", 101, 102, 103, 104);
        check("rel_vld_l4_r4", 32'(vld[2]), 0);
        tick();
        check("rel_vld_l4", 32'(vld[2]), 1);
        chk_data(2, "rel_l4", 101, 102, 103, 104);
        check("rel_vld_l3_r5", 32'(vld[1]), 0);

        // Identity routing (MEM_LAT=1). The q values that count arrive at t+1.
        idle(6);
        set_q(5, 6, 7, 8);
        set_sel(0, 1, 2, 3, 1);
        tick();
        set_sel(0, 0, 0, 0, 0);
        set_q(11, 22, 33, 44);
        check("id_scf_t1", 32'(scf[0]), 0);
        check("id_vld_t1", 32'(vld[0]), 0);
        tick();
        check("id_vld", 32'(vld[0]), 1);
        check("id_scf", 32'(scf[0]), 0);
        chk_data(0, "id", 11, 22, 33, 44);

        // Back-to-back alignment (MEM_LAT=3). At cycle t+k, q_i = 10k + i + 1.
        idle(6);
        for (int k = 0; k < 7; k++) begin
            set_q(10*k + 1, 10*k + 2, 10*k + 3, 10*k + 4);
            if (k == 0)      set_sel(3, 2, 1, 0, 1);
            else if (k == 1) set_sel(1, 0, 3, 2, 1);
            else             set_sel(0, 0, 0, 0, 0);
            tick();
            check("aln_vld", 32'(vld[1]), 32'((k + 1 == 4) || (k + 1 == 5)));
            check("aln_scf", 32'(scf[1]), 0);
            if (k + 1 == 4) chk_data(1, "aln_set1", 34, 33, 32, 31);
            if (k + 1 == 5) chk_data(1, "aln_set2", 42, 41, 44, 43);
        end

        // Hold on invalid (MEM_LAT=1). q keeps changing, so bf_* must freeze.
        idle(6);
        for (int k = 0; k < 7; k++) begin
            set_q(50 + 10*k, 51 + 10*k, 52 + 10*k, 53 + 10*k);
            set_sel(1, 3, 0, 2, (k == 0) ? 1 : 0);
            tick();
            if (k + 1 >= 2) begin
                check("hold_vld", 32'(vld[0]), 32'(k + 1 == 2));
                chk_data(0, "hold", 61, 63, 60, 62);
            end
        end

        // Conflict (MEM_LAT=1): a duplicate read, then a clean read, then a duplicate while idle.
        idle(6);
        check("cfl_pre_err", 32'(cerr[0]), 0);
        set_q(70, 71, 72, 73);
        set_sel(2, 2, 0, 1, 1);
        tick();
        check("cfl_scf_t1", 32'(scf[0]),  1);
        check("cfl_err_t1", 32'(cerr[0]), 1);
        set_sel(0, 1, 2, 3, 1);
        tick();
        check("cfl_scf_t2", 32'(scf[0]),  0);
        check("cfl_err_t2", 32'(cerr[0]), 1);
        chk_data(0, "cfl_dup", 72, 72, 70, 71);
        set_sel(3, 3, 3, 3, 0);
        tick();
        check("cfl_scf_t3", 32'(scf[0]),  0);
        check("cfl_err_t3", 32'(cerr[0]), 1);
        chk_data(0, "cfl_clean", 70, 71, 72, 73);
        tick();
        check("cfl_scf_idle", 32'(scf[0]),  0);
        check("cfl_err_idle", 32'(cerr[0]), 1);
        check("cfl_vld_idle", 32'(vld[0]),  0);

        // Reset mid-flight (MEM_LAT=4): a read at t, then rst during cycle t+2.
        idle(6);
        check("mid_pre_err", 32'(cerr[2]), 1);
        set_q(80, 81, 82, 83);
        set_sel(0, 1, 2, 3, 1);
        tick();
        set_sel(0, 1, 2, 3, 0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_err_clr", 32'(cerr[2]), 0);
        check("mid_vld_t3",  32'(vld[2]),  0);
        check("mid_data_t3", 32'(bu0[2]),  0);
        for (int n = 0; n < 3; n++) begin
            tick();
            check("mid_no_vld", 32'(vld[2]), 0);
        end
        set_q(90, 91, 92, 93);
        set_sel(0, 1, 2, 3, 1);
        tick();
        set_sel(0, 1, 2, 3, 0);
        for (int j = 7; j <= 11; j++) begin
            check("mid_next_vld", 32'(vld[2]), 32'(j == 11));
            if (j == 11) chk_data(2, "mid_next", 90, 91, 92, 93);
            if (j < 11) tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/network_bf_in.md
Name: network_bf_in

Overview:
- Read-side crossbar for the radix-2, 2-BFU NTT datapath.
- Takes read data from the 4 coefficient memory banks and steers it into the upper/lower inputs of butterfly unit 0 and butterfly unit 1.
- The bank-select codes are issued in the same cycle as the read addresses. The block delays them internally to match memory read latency, then registers the routed operands and a valid flag.
- Complements the butterfly-output network on the write side.

Parameters:
- data_width, 14, coefficient width in bits.
- MEM_LAT, 1, bank read latency in cycles from address/select issue to q data; legal range 1..8.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- q0  input  data_width  read data from bank 0.
- q1  input  data_width  read data from bank 1.
- q2  input  data_width  read data from bank 2.
- q3  input  data_width  read data from bank 3.
- sel_b_0  input  2  bank index routed to bf_0_upper; issued with read address.
- sel_b_1  input  2  bank index routed to bf_0_lower.
- sel_b_2  input  2  bank index routed to bf_1_upper.
- sel_b_3  input  2  bank index routed to bf_1_lower.
- rd_en  input  1  read issued this cycle; qualifies the four selects.
- bf_0_upper  output  data_width  registered operand for BFU0 upper input.
- bf_0_lower  output  data_width  registered operand for BFU0 lower input.
- bf_1_upper  output  data_width  registered operand for BFU1 upper input.
- bf_1_lower  output  data_width  registered operand for BFU1 lower input.
- bf_valid  output  1  operands on bf_* are a fresh set.
- sel_conflict  output  1  one-cycle pulse: the issued select set was not a permutation.
- conflict_err  output  1  sticky OR of sel_conflict; cleared only by rst.

Behaviour:
- Single clock domain; everything updates on rising clk. rst is sampled synchronously.
- Reset state: all bf_* = 0, bf_valid = 0, sel_conflict = 0, conflict_err = 0. All select and valid delay stages = 0.
- Select pipeline:
  - {sel_b_0..3, rd_en} enters a MEM_LAT-deep shift register every cycle, unconditionally.
  - The stage-MEM_LAT output, {s0..s3, v}, is aligned with q0..q3.
- Routing is combinational from the delayed selects: code 00->q0, 01->q1, 10->q2, 11->q3. Each output mux is independent.
- Output register:
  - When v=1, bf_0_upper<=mux(s0), bf_0_lower<=mux(s1), bf_1_upper<=mux(s2), bf_1_lower<=mux(s3).
  - When v=0, the bf_* registers hold their previous values.
  - bf_valid<=v every cycle.
- Latency: rd_en high at cycle t gives bf_valid high at t+MEM_LAT+1. Back-to-back rd_en gives back-to-back bf_valid at full throughput, with no bubbles.
- Conflict check is done at issue, not delayed:
  - sel_conflict<=rd_en & (any two of sel_b_0..3 equal). It is registered, so the pulse appears at t+1.
  - conflict_err<=conflict_err | (rd_en & dup).
  - Routing still proceeds on a conflict: duplicated banks feed multiple outputs. No data is dropped.
- Select codes issued with rd_en=0 are ignored for checking. They still shift through the pipeline but cannot update bf_*.
- Reset mid-operation:
  - In-flight selects and valids are flushed. No bf_valid is produced for reads issued before or during rst.
  - The first bf_valid after release comes from the first rd_en sampled with rst=0.
- Simultaneous rst and rd_en: rst wins and that read is discarded.
- Implementation contains no combinational path from any input to any output.

Test Plan:
- Reset: rst high 3 cycles with random q*, rd_en=1 -> all outputs 0 during reset and for MEM_LAT+1 cycles after release. bf_valid rises exactly MEM_LAT+1 cycles after the first post-reset rd_en.
- Identity routing, MEM_LAT=1: sels 0,1,2,3 with rd_en at t; at t+1 drive q0=11, q1=22, q2=33, q3=44 -> at t+2 bf_0_upper=11, bf_0_lower=22, bf_1_upper=33, bf_1_lower=44, bf_valid=1; sel_conflict stays 0.
- Alignment across cycles, MEM_LAT=3: issue sels (3,2,1,0) then (1,0,3,2) on consecutive cycles; q changes each cycle -> bf_valid high 2 consecutive cycles at t+4 and t+5. Each set is routed from the q values present at t+3 and t+4 respectively.
- Hold on invalid: one rd_en followed by idle cycles while q* keep changing -> bf_* frozen at the routed values and bf_valid=0 after the single pulse.
- Conflict: sels (2,2,0,1) with rd_en=1 -> sel_conflict=1 for exactly one cycle; conflict_err=1 thereafter, including after later clean reads. bf_0_upper=bf_0_lower=q2. A duplicate select with rd_en=0 -> no flag.
- Reset mid-flight, MEM_LAT=4: rd_en at t, rst at t+2 -> no bf_valid at t+5; conflict_err cleared; the next read completes normally.
